control_sequencer: RTL and testbench

//  Hardwired control unit for the single-bus CPU datapath. Steps fetch (T0-T2) and per-opcode execute (T3-T7) states.

---
 rtl/control_sequencer.sv | 171 +++++++++++++++++
 tb/tb_control_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus CPU: fetch in T0-T2, per-opcode execute in T3-T7.
// Strobes are decoded combinationally from the current state and IR[31:27].
module control_sequencer #(
  parameter int unsigned    OP_W    = 5,
  parameter logic [OP_W-1:0] ALU_ADD = 5'b00011
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             CON_out,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             CON_in,
  output logic             PCout,
  output logic             ZHIout,
  output logic             ZLOout,
  output logic             MDRout,
  output logic             HIout,
  output logic             LOout,
  output logic             Inportout,
  output logic             Cout,
  output logic             PCin,
  output logic             IRin,
  output logic             MARin,
  output logic             MDRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             HIin,
  output logic             LOin,
  output logic             OutPortin,
  output logic             IncPC,
  output logic             read,
  output logic             write,
  output logic [OP_W-1:0]  operation,
  output logic             run,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;

  state_t          cur, nxt;
  logic [OP_W-1:0] opc;
  logic            is_ld, is_ldi, is_st, is_mem, is_alu, is_imm, is_br;
  logic            is_jr, is_in, is_out, is_mfhi, is_mflo, is_one, is_halt, is_exec;
  logic [OP_W-1:0] imm_op;
  logic            unused_ir;

  assign opc       = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Opcode class decode
  assign is_ld   = (opc == OP_LD);
  assign is_ldi  = (opc == OP_LDI);
  assign is_st   = (opc == OP_ST);
  assign is_mem  = is_ld | is_ldi | is_st;
  assign is_alu  = (opc >= 5'b00011) && (opc <= 5'b01011);
  assign is_imm  = (opc == OP_ADDI) | (opc == OP_ANDI) | (opc == OP_ORI);
  assign is_br   = (opc == OP_BR);
  assign is_jr   = (opc == OP_JR);
  assign is_in   = (opc == OP_IN);
  assign is_out  = (opc == OP_OUT);
  assign is_mfhi = (opc == OP_MFHI);
  assign is_mflo = (opc == OP_MFLO);
  assign is_one  = is_jr | is_in | is_out | is_mfhi | is_mflo;
  assign is_halt = (opc == OP_HALT);
  assign is_exec = is_mem | is_alu | is_imm | is_br | is_one;

  always_comb begin
    imm_op = ALU_ADD;
    if (opc == OP_ANDI) imm_op = OP_AND;
    else if (opc == OP_ORI) imm_op = OP_OR;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) cur <= S_RST;
    else        cur <= nxt;
  end

  // Next state: each opcode class returns to T0 after its last listed state
  always_comb begin
    nxt = cur;
    case (cur)
      S_RST:  nxt = S_T0;
      S_T0:   nxt = S_T1;
      S_T1:   nxt = S_T2;
      S_T2:   nxt = is_halt ? S_HALT : (is_exec ? S_T3 : S_T0);
      S_T3:   nxt = is_one ? S_T0 : S_T4;
      S_T4:   nxt = S_T5;
      S_T5:   nxt = (is_ld | is_st | is_br) ? S_T6 : S_T0;
      S_T6:   nxt = is_br ? S_T0 : S_T7;
      S_T7:   nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; CON_in = 1'b0;
    PCout = 1'b0; ZHIout = 1'b0; ZLOout = 1'b0; MDRout = 1'b0; HIout = 1'b0; LOout = 1'b0;
    Inportout = 1'b0; Cout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0;
    Zhighin = 1'b0; HIin = 1'b0; LOin = 1'b0; OutPortin = 1'b0;
    IncPC = 1'b0; read = 1'b0; write = 1'b0;
    operation = '0;
    case (cur)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
      S_T1: begin ZLOout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_mem) begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
        else if (is_alu | is_imm) begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
        else if (is_br) begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
        else if (is_jr) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
        else if (is_in) begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_out) begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
        else if (is_mfhi) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_mflo) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
      end
      S_T4: begin
        if (is_mem) begin Cout = 1'b1; operation = ALU_ADD; Zlowin = 1'b1; end
        else if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; operation = opc; Zlowin = 1'b1; Zhighin = 1'b1;
        end
        else if (is_imm) begin Cout = 1'b1; operation = imm_op; Zlowin = 1'b1; end
        else if (is_br) begin PCout = 1'b1; Yin = 1'b1; end
      end
      S_T5: begin
        if (is_ld | is_st) begin ZLOout = 1'b1; MARin = 1'b1; end
        else if (is_ldi | is_alu | is_imm) begin ZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_br) begin Cout = 1'b1; operation = ALU_ADD; Zlowin = 1'b1; end
      end
      S_T6: begin
        if (is_ld) begin read = 1'b1; MDRin = 1'b1; end
        else if (is_st) begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
        else if (is_br && CON_out) begin ZLOout = 1'b1; PCin = 1'b1; end
      end
      S_T7: begin
        if (is_ld) begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
        else if (is_st) write = 1'b1;
      end
      default: ;
    endcase
  end

  assign run   = (cur != S_RST) && (cur != S_HALT);
  assign state = 4'(cur);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-opcode strobe schedules written as name lists and
// compared cycle by cycle, with directed cases followed by random opcodes and random aborts.
module tb_control_sequencer;

  logic clock, clear, CON_out;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
  logic PCout, ZHIout, ZLOout, MDRout, HIout, LOout, Inportout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin;
  logic IncPC, read, write, run;
  logic [4:0] operation;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  string steps_s[$];
  int    steps_op[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_out(CON_out),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .CON_in(CON_in),
    .PCout(PCout), .ZHIout(ZHIout), .ZLOout(ZLOout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .Inportout(Inportout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zlowin(Zlowin),
    .Zhighin(Zhighin), .HIin(HIin), .LOin(LOin), .OutPortin(OutPortin),
    .IncPC(IncPC), .read(read), .write(write),
    .operation(operation), .run(run), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [27:0] strobes();
    return {Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
            PCout, ZHIout, ZLOout, MDRout, HIout, LOout, Inportout, Cout,
            PCin, IRin, MARin, MDRin, Yin, Zlowin, Zhighin, HIin, LOin, OutPortin,
            IncPC, read, write};
  endfunction

  // Same order as the strobes() concatenation, MSB first
  function automatic int name_idx(string t);
    string names[28] = '{"Gra", "Grb", "Grc", "Rin", "Rout", "BAout", "CON_in",
                         "PCout", "ZHIout", "ZLOout", "MDRout", "HIout", "LOout", "Inportout", "Cout",
                         "PCin", "IRin", "MARin", "MDRin", "Yin", "Zlowin", "Zhighin", "HIin", "LOin",
                         "OutPortin", "IncPC", "read", "write"};
    for (int k = 0; k < 28; k++) if (names[k] == t) return k;
    return -1;
  endfunction

  function automatic logic [27:0] mask_of(string s);
    logic [27:0] m = '0;
    string tok = "";
    int k;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s.substr(i, i) == " ") begin
        if (tok.len() > 0) begin
          k = name_idx(tok);
          if (k >= 0) m = m | (28'(1) << (27 - k));
          tok = "";
        end
      end else tok = {tok, s.substr(i, i)};
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void add_step(string s, int op);
    steps_s.push_back(s);
    steps_op.push_back(op);
  endfunction

  // Reference schedule: fetch then the execute list for the opcode
  function automatic void build(logic [4:0] opc, bit con);
    steps_s.delete();
    steps_op.delete();
    add_step("PCout MARin IncPC Zlowin", 0);
    add_step("ZLOout PCin read MDRin", 0);
    add_step("MDRout IRin", 0);
    if (opc <= 2) begin
      add_step("Grb BAout Yin", 0);
      add_step("Cout Zlowin", 3);
      if (opc == 1) add_step("ZLOout Gra Rin", 0);
      else add_step("ZLOout MARin", 0);
      if (opc == 0) begin
        add_step("read MDRin", 0);
        add_step("MDRout Gra Rin", 0);
      end else if (opc == 2) begin
        add_step("Gra Rout MDRin", 0);
        add_step("write", 0);
      end
    end else if (opc <= 11) begin
      add_step("Grb Rout Yin", 0);
      add_step("Grc Rout Zlowin Zhighin", int'(opc));
      add_step("ZLOout Gra Rin", 0);
    end else if (opc <= 14) begin
      add_step("Grb Rout Yin", 0);
      add_step("Cout Zlowin", opc == 12 ? 3 : (opc == 13 ? 5 : 6));
      add_step("ZLOout Gra Rin", 0);
    end else if (opc == 18) begin
      add_step("Gra Rout CON_in", 0);
      add_step("PCout Yin", 0);
      add_step("Cout Zlowin", 3);
      add_step(con ? "ZLOout PCin" : "", 0);
    end else if (opc == 19) add_step("Gra Rout PCin", 0);
    else if (opc == 22) add_step("Inportout Gra Rin", 0);
    else if (opc == 23) add_step("Gra Rout OutPortin", 0);
    else if (opc == 24) add_step("HIout Gra Rin", 0);
    else if (opc == 25) add_step("LOout Gra Rin", 0);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".strb"}, 32'(strobes()), 32'h0);
    chk({tag, ".op"}, 32'(operation), 32'h0);
    chk({tag, ".run"}, 32'(run), 32'h0);
  endtask

  task automatic check_invariants(input string tag);
    int drv;
    drv = int'(Rout) + int'(BAout) + int'(PCout) + int'(ZHIout) + int'(ZLOout) + int'(MDRout)
        + int'(HIout) + int'(LOout) + int'(Inportout) + int'(Cout);
    chk({tag, ".onebus"}, 32'(drv <= 1), 32'h1);
    chk({tag, ".rdwr"}, 32'(read & write), 32'h0);
  endtask

  // Run one instruction starting at T0; abort_at >= 0 pulls clear low after that step
  task automatic run_instr(input string tag, input logic [31:0] ir, input bit con, input int abort_at);
    build(ir[31:27], con);
    for (int i = 0; i < steps_s.size(); i++) begin
      @(negedge clock);
      if (i == 0) begin
        IR = ir;
        CON_out = con;
      end
      #1;
      chk($sformatf("%s.t%0d.strb", tag, i), 32'(strobes()), 32'(mask_of(steps_s[i])));
      chk($sformatf("%s.t%0d.op", tag, i), 32'(operation), 32'(steps_op[i]));
      chk($sformatf("%s.t%0d.run", tag, i), 32'(run), 32'h1);
      check_invariants(tag);
      if (i == abort_at) begin
        clear = 1'b0;
        #1 check_idle({tag, ".abort"});
        @(negedge clock);
        check_idle({tag, ".abort_hold"});
        clear = 1'b1;
        return;
      end
    end
    if (ir[31:27] == 5'b11011) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clock);
        check_idle($sformatf("%s.halt%0d", tag, c));
      end
      clear = 1'b0;
      #1 check_idle({tag, ".halt_clr"});
      @(negedge clock);
      clear = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] ir;
    int ab;
    clear = 1'b0;
    IR = '0;
    CON_out = 1'b0;
    repeat (3) @(negedge clock);
    check_idle("reset");
    clear = 1'b1;

    run_instr("ld",   32'h00900054, 1'b0, -1);
    run_instr("add",  32'h1A920000, 1'b0, -1);
    run_instr("br1",  32'h9180000E, 1'b1, -1);
    run_instr("br0",  32'h9180000E, 1'b0, -1);
    run_instr("st",   32'h10800087, 1'b0, -1);
    run_instr("undef", 32'hF8000000, 1'b0, -1);
    run_instr("ldab", 32'h00900054, 1'b0, 6);
    run_instr("halt", 32'hD8000000, 1'b0, -1);
    run_instr("ldi",  32'h08900054, 1'b0, -1);

    for (int n = 0; n < 200; n++) begin
      ir = $urandom;
      if (ir[31:27] == 5'b11011 && ($urandom_range(0, 3) != 0)) ir[31:27] = 5'b00011;
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr($sformatf("rnd%0d", n), ir, 1'($urandom), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
